rf_pulse_tx: RTL and testbench

- Transmit-side counterpart of the RFIN pulse receiver in the APB/SPI receive path.
- Collects one packet of PKT_BYTES bytes over a valid/ready byte interface, then serialises it onto o_RF_OUT as on-off-keyed pulses.
- Each packet is an all-ones preamble followed by the payload, MSB first. A '1' slot carries a short pulse at a fixed offset; a '0' slot carries no pulse.
- Used to drive the receiver RF input in loopback tests and as the on-chip TX modulator.

---
 rtl/rf_pulse_tx_if.sv | 24 ++
 rtl/rf_pulse_tx.sv | 172 +++++++++++++++++
 tb/tb_rf_pulse_tx.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_pulse_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_pulse_tx_if
// Brief    : Byte-wide valid/ready load interface for the OOK pulse transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface rf_pulse_tx_if;
    logic [7:0] i_TX_DATA;
    logic       i_TX_VALID;
    logic       o_TX_READY;

    modport master (
        output i_TX_DATA,
        output i_TX_VALID,
        input  o_TX_READY
    );

    modport slave (
        input  i_TX_DATA,
        input  i_TX_VALID,
        output o_TX_READY
    );
endinterface
`default_nettype wire

// File: rtl/rf_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : rf_pulse_tx
// Brief    : Loads a packet over valid/ready and sends preamble+payload as OOK pulses.
// Revision : 1.0  initial release
// ============================================================================
module rf_pulse_tx #(
    parameter int PKT_BYTES    = 8,
    parameter int PRE_BITS     = 8,
    parameter int BIT_CYCLES   = 10000,
    parameter int PULSE_OFFSET = 5000,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 8
) (
    input  logic         i_PCLK,
    input  logic         i_PRESETn,
    rf_pulse_tx_if.slave tx_if,
    input  logic         i_ABORT,
    output logic         o_RF_OUT,
    output logic         o_SH_EN,
    output logic [6:0]   o_BIT_IDX,
    output logic         o_BUSY,
    output logic         o_PKT_DONE
);

    localparam int SR_W        = 8 * PKT_BYTES;
    localparam int TOTAL_SLOTS = PRE_BITS + SR_W;
    localparam int CNT_MAX     = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int BC_W        = $clog2(PKT_BYTES + 1);

    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] c_pulse_lo  = CNT_W'(PULSE_OFFSET);
    localparam logic [CNT_W-1:0] c_pulse_hi  = CNT_W'(PULSE_OFFSET + PULSE_CYCLES);
    localparam logic [6:0]       c_pre_last  = 7'(PRE_BITS - 1);
    localparam logic [6:0]       c_slot_last = 7'(TOTAL_SLOTS - 1);
    localparam logic [BC_W-1:0]  c_byte_last = BC_W'(PKT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [6:0]        slot_q,     slot_d;
    logic [SR_W-1:0]   sr_q,       sr_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic              rf_q,       rf_d;
    logic              sh_en_q,    sh_en_d;
    logic [6:0]        bit_idx_q,  bit_idx_d;
    logic              busy_q,     busy_d;
    logic              ready_q,    ready_d;
    logic              done_q,     done_d;

    logic              accept;
    logic              in_slot;
    logic              slot_bit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        sr_d       = sr_q;
        byte_cnt_d = byte_cnt_q;
        done_d     = 1'b0;
        accept     = tx_if.i_TX_VALID & ready_q;

        if (i_ABORT) begin
            state_d    = ST_LOAD;
            cnt_d      = '0;
            slot_d     = '0;
            sr_d       = '0;
            byte_cnt_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        sr_d = (sr_q << 8) | SR_W'(tx_if.i_TX_DATA);
                        if (byte_cnt_q == c_byte_last) begin
                            state_d    = ST_PRE;
                            byte_cnt_d = '0;
                            cnt_d      = '0;
                            slot_d     = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PRE, ST_DATA: begin
                    if (cnt_q == c_bit_last) begin
                        cnt_d = '0;
                        // Preamble slots leave the payload untouched so its MSB leads DATA.
                        if (state_q == ST_DATA) begin
                            sr_d = sr_q << 1;
                        end
                        if (slot_q == c_slot_last) begin
                            slot_d  = '0;
                            done_d  = 1'b1;
                            state_d = (GAP_CYCLES == 0) ? ST_LOAD : ST_GAP;
                        end else begin
                            slot_d = slot_q + 1'b1;
                            if (slot_q == c_pre_last) begin
                                state_d = ST_DATA;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == c_gap_last) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end

        // Outputs are decoded from next-state values so the registered copies line up with the counters.
        in_slot   = (state_d == ST_PRE) || (state_d == ST_DATA);
        slot_bit  = (state_d == ST_PRE) ? 1'b1 : sr_d[SR_W-1];
        rf_d      = in_slot && slot_bit && (cnt_d >= c_pulse_lo) && (cnt_d < c_pulse_hi);
        sh_en_d   = in_slot && (cnt_d == '0);
        bit_idx_d = in_slot ? slot_d : 7'd0;
        busy_d    = (state_d != ST_LOAD);
        ready_d   = (state_d == ST_LOAD);
    end

    always_ff @(posedge i_PCLK) begin
        if (!i_PRESETn) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            slot_q     <= '0;
            sr_q       <= '0;
            byte_cnt_q <= '0;
            rf_q       <= 1'b0;
            sh_en_q    <= 1'b0;
            bit_idx_q  <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            sr_q       <= sr_d;
            byte_cnt_q <= byte_cnt_d;
            rf_q       <= rf_d;
            sh_en_q    <= sh_en_d;
            bit_idx_q  <= bit_idx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx_if.o_TX_READY = ready_q;
    assign o_RF_OUT         = rf_q;
    assign o_SH_EN          = sh_en_q;
    assign o_BIT_IDX        = bit_idx_q;
    assign o_BUSY           = busy_q;
    assign o_PKT_DONE       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_pulse_tx
// Brief    : Directed self-checking bench for rf_pulse_tx (20-cycle slots, 2-cycle pulses).
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_pulse_tx;

    logic       clk = 1'b0;
    logic       presetn;
    logic       abort;
    logic       rf_out;
    logic       sh_en;
    logic [6:0] bit_idx;
    logic       busy;
    logic       pkt_done;
    int         n_pass  = 0;
    int         n_total = 0;

    rf_pulse_tx_if tx_if ();

    rf_pulse_tx #(
        .PKT_BYTES   (8),
        .PRE_BITS    (8),
        .BIT_CYCLES  (20),
        .PULSE_OFFSET(10),
        .PULSE_CYCLES(2),
        .GAP_CYCLES  (8)
    ) dut (
        .i_PCLK    (clk),
        .i_PRESETn (presetn),
        .tx_if     (tx_if),
        .i_ABORT   (abort),
        .o_RF_OUT  (rf_out),
        .o_SH_EN   (sh_en),
        .o_BIT_IDX (bit_idx),
        .o_BUSY    (busy),
        .o_PKT_DONE(pkt_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives 8 bytes first-to-last; returns at the negedge of the cycle after the last handshake.
    task automatic send_bytes(input logic [63:0] payload, input bit gaps, output int cycles);
        int wait_n;
        cycles = 0;
        for (int b = 0; b < 8; b++) begin
            tx_if.i_TX_DATA  = payload[63-8*b -: 8];
            tx_if.i_TX_VALID = 1'b1;
            wait_n = 0;
            while (tx_if.o_TX_READY !== 1'b1 && wait_n < 3000) begin
                @(negedge clk);
                wait_n++;
                cycles++;
            end
            if (wait_n >= 3000) begin
                n_total++;
                $display("FAIL send_timeout: byte %0d ready=%b required 1", b, tx_if.o_TX_READY);
                tx_if.i_TX_VALID = 1'b0;
                return;
            end
            @(negedge clk);
            cycles++;
            if (gaps && b < 7) begin
                int n;
                n = $urandom_range(0, 3);
                tx_if.i_TX_VALID = 1'b0;
                repeat (n) begin
                    @(negedge clk);
                    cycles++;
                end
            end
        end
        tx_if.i_TX_VALID = 1'b0;
    endtask

    // Records one packet (1440 cycles) starting at the T0 negedge; ends at the negedge of T0+1440.
    task automatic observe_packet(output logic [71:0] bits, output int pulses, output int shape_err,
                                  output int sh_err, output int idx_err, output int max_idx,
                                  output int data_hi);
        logic prev;
        logic at10;
        int   slot;
        int   off;
        bits = '0; pulses = 0; shape_err = 0; sh_err = 0; idx_err = 0; max_idx = 0; data_hi = 0;
        prev = 1'b0; at10 = 1'b0;
        for (int k = 0; k < 1440; k++) begin
            slot = k / 20;
            off  = k % 20;
            if (rf_out === 1'b1 && prev !== 1'b1) pulses++;
            if (rf_out === 1'b1) bits[71-slot] = 1'b1;
            if (rf_out !== 1'b0 && (off < 10 || off > 11)) shape_err++;
            if (off == 10) at10 = rf_out;
            if (off == 11 && rf_out !== at10) shape_err++;
            if (sh_en !== (off == 0)) sh_err++;
            if (bit_idx !== 7'(slot)) idx_err++;
            if (int'(bit_idx) > max_idx) max_idx = int'(bit_idx);
            if (slot >= 8 && rf_out !== 1'b0) data_hi++;
            prev = rf_out;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0; abort = 1'b0;
        tx_if.i_TX_VALID = 1'b0; tx_if.i_TX_DATA = 8'h00;
        @(negedge clk);
        n_total++;
        if ({rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY} !== 12'h000)
            $display("FAIL reset_outputs: got %b required all zero",
                     {rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY});
        else n_pass++;
        presetn = 1'b1;
        @(negedge clk);
        n_total++;
        if ({tx_if.o_TX_READY, busy, sh_en, rf_out, pkt_done} !== 5'b10000)
            $display("FAIL reset_release: got ready/busy/sh/rf/done=%b required 10000",
                     {tx_if.o_TX_READY, busy, sh_en, rf_out, pkt_done});
        else n_pass++;
    endtask

    task automatic test_packet();
        logic [71:0] bits; int pulses, shp, she, idxe, mx, dh, cyc;
        send_bytes(64'h8123456789ABCD0F, 1'b0, cyc);
        n_total++;
        if ({tx_if.o_TX_READY, busy, sh_en} !== 3'b011)
            $display("FAIL t0_state: got ready/busy/sh=%b required 011", {tx_if.o_TX_READY, busy, sh_en});
        else n_pass++;
        observe_packet(bits, pulses, shp, she, idxe, mx, dh);
        n_total++;
        if (bits !== 72'hFF_8123456789ABCD0F) $display("FAIL pkt1_bits: got %h required FF8123456789ABCD0F", bits);
        else n_pass++;
        n_total++;
        if (pulses !== 38) $display("FAIL pkt1_pulses: got %0d required 38", pulses);
        else n_pass++;
        n_total++;
        if (shp !== 0 || she !== 0 || idxe !== 0)
            $display("FAIL pkt1_timing: shape=%0d sh_en=%0d idx=%0d errors required 0", shp, she, idxe);
        else n_pass++;
        n_total++;
        if ({pkt_done, busy, tx_if.o_TX_READY} !== 3'b110)
            $display("FAIL pkt1_done_t1440: got done/busy/ready=%b required 110", {pkt_done, busy, tx_if.o_TX_READY});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (pkt_done !== 1'b0) $display("FAIL pkt1_done_width: got %b required 0", pkt_done);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_total++;
        if ({tx_if.o_TX_READY, busy} !== 2'b01)
            $display("FAIL pkt1_gap_end_t1447: got ready/busy=%b required 01", {tx_if.o_TX_READY, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({tx_if.o_TX_READY, busy} !== 2'b10)
            $display("FAIL pkt1_ready_t1448: got ready/busy=%b required 10", {tx_if.o_TX_READY, busy});
        else n_pass++;
    endtask

    task automatic test_zero_payload();
        logic [71:0] bits; int pulses, shp, she, idxe, mx, dh, cyc;
        send_bytes(64'h0, 1'b0, cyc);
        observe_packet(bits, pulses, shp, she, idxe, mx, dh);
        n_total++;
        if (bits !== {8'hFF, 64'h0}) $display("FAIL zero_bits: got %h required FF0000000000000000", bits);
        else n_pass++;
        n_total++;
        if (pulses !== 8 || dh !== 0) $display("FAIL zero_pulses: got %0d pulses %0d data-high cycles required 8 and 0", pulses, dh);
        else n_pass++;
        n_total++;
        if (mx !== 71) $display("FAIL zero_max_idx: got %0d required 71", mx);
        else n_pass++;
        repeat (8) @(negedge clk);
        n_total++;
        if (tx_if.o_TX_READY !== 1'b1) $display("FAIL zero_ready_return: got %b required 1", tx_if.o_TX_READY);
        else n_pass++;
    endtask

    task automatic test_gaps_and_busy_valid();
        logic [71:0] bits; int pulses, shp, she, idxe, mx, dh, cyc;
        logic done_seen;
        send_bytes(64'hDEADBEEF01020304, 1'b1, cyc);
        fork
            begin
                observe_packet(bits, pulses, shp, she, idxe, mx, dh);
                done_seen = pkt_done;
            end
            begin
                for (int i = 0; i < 1446; i++) begin
                    tx_if.i_TX_VALID = (i % 3) != 0;
                    tx_if.i_TX_DATA  = 8'hEE;
                    @(negedge clk);
                end
                tx_if.i_TX_VALID = 1'b0;
            end
        join
        n_total++;
        if (bits !== 72'hFF_DEADBEEF01020304) $display("FAIL gaps_bits: got %h required FFDEADBEEF01020304", bits);
        else n_pass++;
        n_total++;
        if (pulses !== 37 || shp !== 0) $display("FAIL gaps_pulses: got %0d pulses %0d shape errors required 37 and 0", pulses, shp);
        else n_pass++;
        n_total++;
        if (done_seen !== 1'b1) $display("FAIL gaps_done: got %b required 1", done_seen);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (tx_if.o_TX_READY !== 1'b1) $display("FAIL gaps_ready_return: got %b required 1", tx_if.o_TX_READY);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [71:0] bits; int pulses, shp, she, idxe, mx, dh, cyc, done_cnt;
        // Three bytes, then a fourth offered together with abort: all must be discarded.
        for (int b = 0; b < 3; b++) begin
            tx_if.i_TX_DATA = 8'h11 * 8'(b + 1); tx_if.i_TX_VALID = 1'b1;
            @(negedge clk);
        end
        tx_if.i_TX_DATA = 8'h77; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; tx_if.i_TX_VALID = 1'b0;
        n_total++;
        if ({tx_if.o_TX_READY, busy} !== 2'b10) $display("FAIL abort_load: got ready/busy=%b required 10", {tx_if.o_TX_READY, busy});
        else n_pass++;
        send_bytes(64'hFFFFFFFFFFFFFFFF, 1'b0, cyc);
        repeat (810) @(negedge clk);
        n_total++;
        if ({rf_out, bit_idx} !== {1'b1, 7'd40}) $display("FAIL abort_prepulse: got rf/idx=%b/%0d required 1/40", rf_out, bit_idx);
        else n_pass++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if ({rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY} !== 12'b000000000001)
            $display("FAIL abort_next_cycle: got %b required 000000000001",
                     {rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY});
        else n_pass++;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (pkt_done !== 1'b0 || busy !== 1'b0) done_cnt++;
        end
        n_total++;
        if (done_cnt !== 0) $display("FAIL abort_no_done: got %0d done/busy cycles required 0", done_cnt);
        else n_pass++;
        send_bytes(64'h0F1E2D3C4B5A6978, 1'b0, cyc);
        observe_packet(bits, pulses, shp, she, idxe, mx, dh);
        n_total++;
        if (bits !== 72'hFF_0F1E2D3C4B5A6978 || pulses !== 40)
            $display("FAIL abort_next_pkt: got %h with %0d pulses required FF0F1E2D3C4B5A6978 with 40", bits, pulses);
        else n_pass++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        int cyc, hi_cnt;
        send_bytes(64'h3C3C3C3C3C3C3C3C, 1'b0, cyc);
        repeat (50) @(negedge clk);
        n_total++;
        if (rf_out !== 1'b1) $display("FAIL rst_prepulse: got rf=%b required 1", rf_out);
        else n_pass++;
        presetn = 1'b0;
        @(negedge clk);
        presetn = 1'b1;
        n_total++;
        if ({rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY} !== 12'h000)
            $display("FAIL rst_mid_outputs: got %b required all zero",
                     {rf_out, sh_en, bit_idx, busy, pkt_done, tx_if.o_TX_READY});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({tx_if.o_TX_READY, busy, rf_out} !== 3'b100)
            $display("FAIL rst_mid_load: got ready/busy/rf=%b required 100", {tx_if.o_TX_READY, busy, rf_out});
        else n_pass++;
        hi_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (rf_out !== 1'b0 || busy !== 1'b0) hi_cnt++;
        end
        n_total++;
        if (hi_cnt !== 0) $display("FAIL rst_no_resume: got %0d active cycles required 0", hi_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [71:0] bits; int pulses, shp, she, idxe, mx, dh, cyc;
        send_bytes({8{8'hA5}}, 1'b0, cyc);
        observe_packet(bits, pulses, shp, she, idxe, mx, dh);
        n_total++;
        if (bits !== {8'hFF, {8{8'hA5}}} || pulses !== 40)
            $display("FAIL b2b_pkt1: got %h with %0d pulses required FFA5A5A5A5A5A5A5A5 with 40", bits, pulses);
        else n_pass++;
        n_total++;
        if (pkt_done !== 1'b1) $display("FAIL b2b_done1: got %b required 1", pkt_done);
        else n_pass++;
        send_bytes({8{8'h5A}}, 1'b0, cyc);
        n_total++;
        if (cyc !== 16 || sh_en !== 1'b1) $display("FAIL b2b_t0_spacing: got %0d cycles sh=%b required 16 cycles sh=1", cyc, sh_en);
        else n_pass++;
        observe_packet(bits, pulses, shp, she, idxe, mx, dh);
        n_total++;
        if (bits !== {8'hFF, {8{8'h5A}}} || pulses !== 40 || shp !== 0 || she !== 0 || idxe !== 0)
            $display("FAIL b2b_pkt2: got %h pulses=%0d errs=%0d/%0d/%0d required FF5A5A5A5A5A5A5A5A 40 0/0/0",
                     bits, pulses, shp, she, idxe);
        else n_pass++;
        n_total++;
        if (pkt_done !== 1'b1) $display("FAIL b2b_done2: got %b required 1", pkt_done);
        else n_pass++;
        repeat (8) @(negedge clk);
        n_total++;
        if (tx_if.o_TX_READY !== 1'b1) $display("FAIL b2b_ready_return: got %b required 1", tx_if.o_TX_READY);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_zero_payload();
        test_gaps_and_busy_valid();
        test_abort();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
